// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encoding, status flag bit
// positions within {n,z,c,v}, and the arbiter FSM state encoding.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b101
  } op_e;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU shared by both requesters of alu_arbiter.
// ADD/SUB produce carry (borrow for SUB) as bit N of an N+1-bit result and
// signed overflow; logic ops and SLT clear c and v. Unknown opcodes return
// zero with err set.
module alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] result,
  output logic [3:0]   status,
  output logic         err
);

  logic [N:0] wide;
  logic       c;
  logic       v;

  // Decode the opcode and derive result plus {n,z,c,v}
  always_comb begin
    wide   = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[N-1:0];
        c      = wide[N];
        v      = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[N-1:0];
        c      = wide[N];
        v      = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLT:  result = {{(N-1){1'b0}}, (a < b)};
      default: err = 1'b1;
    endcase
    status       = '0;
    status[ST_N] = result[N-1];
    status[ST_Z] = (result == '0);
    status[ST_C] = c;
    status[ST_V] = v;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end time-sharing one ALU via valid/ready handshakes.
// IDLE grants one requester and captures its operands; RESP presents the
// result to that owner until it is accepted. At most one op per two cycles.
// Build option ALU_ARB_RR_EN: round-robin grant on contention (default is
// fixed priority, requester 0 first).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a [2],
  input  logic [N-1:0] req_b [2],
  input  logic [2:0]   req_op [2],
  output logic [1:0]   resp_valid,
  input  logic [1:0]   resp_ready,
  output logic [N-1:0] resp_result,
  output logic [3:0]   resp_status,
  output logic         resp_err
);

  state_e       state_q;
  state_e       state_d;
  logic         win;
  logic [1:0]   grant;
  logic         accept;
  logic         resp_done;
  logic [N-1:0] a_p1;
  logic [N-1:0] b_p1;
  logic [2:0]   op_p1;
  logic         owner_p1;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_status;
  logic         alu_err;

`ifdef ALU_ARB_RR_EN
  logic last_grant;

  // On contention the requester that did not win last time goes first
  always_comb begin
    if (&req_valid) win = ~last_grant;
    else            win = ~req_valid[0];
  end

  // Remember the most recent winner; reset favours requester 0 next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= win;
  end
`else
  assign win = ~req_valid[0];
`endif

  assign grant = (|req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    accept     = 1'b0;
    resp_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = rst_n ? grant : 2'b00;
        accept    = |(req_valid & req_ready);
        if (accept) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = owner_p1 ? 2'b10 : 2'b01;
        resp_done  = |(resp_valid & resp_ready);
        if (resp_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage p1: operands captured on accept, held through RESP ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p1     <= '0;
      b_p1     <= '0;
      op_p1    <= '0;
      owner_p1 <= 1'b0;
    end else if (accept) begin
      a_p1     <= req_a[win];
      b_p1     <= req_b[win];
      op_p1    <= req_op[win];
      owner_p1 <= win;
    end
  end

  alu #(.N(N)) u_alu (
    .a      (a_p1),
    .b      (b_p1),
    .op     (op_p1),
    .result (alu_result),
    .status (alu_status),
    .err    (alu_err)
  );

  assign resp_result = (state_q == S_RESP) ? alu_result : '0;
  assign resp_status = (state_q == S_RESP) ? alu_status : 4'b0000;
  assign resp_err    = (state_q == S_RESP) ? alu_err    : 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, randomized ops
// against a wide-integer reference model, and hand-written sequences for
// back-pressure, reset during a response and contention. Honors
// ALU_ARB_RR_EN for the expected grant order.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMAX = 64'sd4294967295;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] req_a [2];
  logic [N-1:0] req_b [2];
  logic [2:0]   req_op [2];
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [N-1:0] resp_result;
  logic [3:0]   resp_status;
  logic         resp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_status (resp_status),
    .resp_err    (resp_err)
  );

  typedef struct {
    int          who;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [31:0] r;
    logic [3:0]  st;
    logic        e;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int who);
    return (who == 1) ? 2'b10 : 2'b01;
  endfunction

  // Reference model: plain 64-bit integer arithmetic on the operand values
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] st, output logic e);
    longint ua, ub, sa, sb, res, sres;
    logic c, v;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; e = 1'b0; r = '0;
    case (op)
      3'd0: begin
        res = ua + ub; sres = sa + sb;
        r = res[31:0]; c = (res > UMAX); v = (sres > SMAX) || (sres < SMIN);
      end
      3'd1: begin
        res = ua - ub; sres = sa - sb;
        r = res[31:0]; c = (res < 0); v = (sres > SMAX) || (sres < SMIN);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = (ua < ub) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    st = {r[31], (r == 32'd0), c, v};
  endfunction

  // One request/response transaction with optional response back-pressure
  task automatic do_op(input int who, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] r, output logic [3:0] st, output logic e);
    logic [31:0] r0;
    logic [3:0]  s0;
    logic        e0;
    @(negedge clk);
    req_valid = onehot(who);
    req_a[who] = a; req_b[who] = b; req_op[who] = op;
    resp_ready = 2'b00;
    #1 check("req_ready_idle", req_ready, onehot(who));
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("resp_valid", resp_valid, onehot(who));
    r0 = resp_result; s0 = resp_status; e0 = resp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", resp_valid, onehot(who));
      check("hold_result", resp_result, r0);
      check("hold_status", resp_status, s0);
      check("hold_req_ready", req_ready, 2'b00);
    end
    r = r0; st = s0; e = e0;
    resp_ready = onehot(who);
    @(posedge clk); #1;
    resp_ready = 2'b00;
    check("resp_valid_done", resp_valid, 2'b00);
    check("idle_result_zero", {resp_result, resp_status, resp_err}, '0);
  endtask

  initial begin
    logic [31:0] r, a, b, er;
    logic [3:0]  st, est;
    logic        e, ee;
    logic [2:0]  op;
    int          who, exp_w, last;
    bit          rr;

`ifdef ALU_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif

    tbl.push_back('{0, 3'b000, 32'd5,          32'd7,          0, 32'd12,         4'b0000, 1'b0});
    tbl.push_back('{1, 3'b001, 32'h8000_0000,  32'd1,          3, 32'h7FFF_FFFF,  4'b0001, 1'b0});
    tbl.push_back('{0, 3'b001, 32'd3,          32'd3,          0, 32'd0,          4'b0100, 1'b0});
    tbl.push_back('{1, 3'b000, 32'hFFFF_FFFF,  32'd1,          0, 32'd0,          4'b0110, 1'b0});
    tbl.push_back('{0, 3'b000, 32'h7FFF_FFFF,  32'd1,          1, 32'h8000_0000,  4'b1001, 1'b0});
    tbl.push_back('{1, 3'b001, 32'd1,          32'd2,          0, 32'hFFFF_FFFF,  4'b1010, 1'b0});
    tbl.push_back('{0, 3'b010, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  0, 32'h00F0_00F0,  4'b0000, 1'b0});
    tbl.push_back('{1, 3'b011, 32'h8000_0000,  32'd1,          0, 32'h8000_0001,  4'b1000, 1'b0});
    tbl.push_back('{0, 3'b101, 32'd1,          32'hFFFF_FFFF,  0, 32'd1,          4'b0000, 1'b0});
    tbl.push_back('{1, 3'b101, 32'hFFFF_FFFF,  32'd1,          0, 32'd0,          4'b0100, 1'b0});
    tbl.push_back('{0, 3'b111, 32'd9,          32'd4,          0, 32'd0,          4'b0100, 1'b1});
    tbl.push_back('{0, 3'b000, 32'd1,          32'd1,          0, 32'd2,          4'b0000, 1'b0});
    tbl.push_back('{1, 3'b100, 32'd9,          32'd4,          0, 32'd0,          4'b0100, 1'b1});
    tbl.push_back('{0, 3'b110, 32'd9,          32'd4,          1, 32'd0,          4'b0100, 1'b1});

    rst_n = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = '0; req_b[i] = '0; req_op[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_resp_valid", resp_valid, 2'b00);
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_outputs", {resp_result, resp_status, resp_err}, '0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors
    foreach (tbl[i]) begin
      do_op(tbl[i].who, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, r, st, e);
      check($sformatf("vec%0d_result", i), r, tbl[i].r);
      check($sformatf("vec%0d_status", i), st, tbl[i].st);
      check($sformatf("vec%0d_err", i), e, tbl[i].e);
    end

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      who = int'($urandom_range(1, 0));
      op  = 3'($urandom_range(7, 0));
      case ($urandom_range(4, 0))
        0: a = 32'h0; 1: a = 32'h8000_0000; 2: a = 32'h7FFF_FFFF; 3: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(4, 0))
        0: b = 32'h0; 1: b = 32'h1; 2: b = 32'h7FFF_FFFF; 3: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      model(op, a, b, er, est, ee);
      do_op(who, op, a, b, int'($urandom_range(2, 0)), r, st, e);
      check($sformatf("rand%0d_result", i), r, er);
      check($sformatf("rand%0d_status", i), st, est);
      check($sformatf("rand%0d_err", i), e, ee);
    end

    // Reset asserted while a response is pending
    @(negedge clk);
    req_valid = 2'b01; req_a[0] = 32'd1; req_b[0] = 32'd2; req_op[0] = 3'b000;
    resp_ready = 2'b00;
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("pre_reset_resp_valid", resp_valid, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_resp_valid", resp_valid, 2'b00);
    check("async_reset_req_ready", req_ready, 2'b00);
    check("async_reset_outputs", {resp_result, resp_status, resp_err}, '0);
    @(negedge clk); rst_n = 1'b1;

    // Continuous contention from both requesters
    @(negedge clk);
    req_a[0] = 32'd10; req_b[0] = 32'd1; req_op[0] = 3'b000;
    req_a[1] = 32'd10; req_b[1] = 32'd1; req_op[1] = 3'b001;
    req_valid = 2'b11; resp_ready = 2'b11;
    last = 1;
    for (int k = 0; k < 4; k++) begin
      exp_w = rr ? ((last == 1) ? 0 : 1) : 0;
      last = exp_w;
      #1;
      check($sformatf("contend%0d_req_ready", k), req_ready, onehot(exp_w));
      @(posedge clk); #1;
      check($sformatf("contend%0d_resp_valid", k), resp_valid, onehot(exp_w));
      check($sformatf("contend%0d_req_ready_resp", k), req_ready, 2'b00);
      check($sformatf("contend%0d_result", k), resp_result, (exp_w == 1) ? 32'd9 : 32'd11);
      @(posedge clk);
    end
    #1;
    req_valid = 2'b00; resp_ready = 2'b00;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, 32, operand/result bit width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  [1:0]  per-requester operation request.
REQ-005 req_ready  output  [1:0]  per-requester accept; at most one bit set.
REQ-006 req_a, req_b  input  2 x N unpacked  per-requester operands.
REQ-007 req_op  input  2 x 3 unpacked  per-requester opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
REQ-008 resp_valid  output  [1:0]  one-hot response to the owning requester.
REQ-009 resp_ready  input  [1:0]  per-requester response accept.
REQ-010 resp_result  output  N  shared result bus.
REQ-011 resp_status  output  4  shared {n,z,c,v} flags.
REQ-012 resp_err  output  1  illegal opcode flag for the current response.

Function
REQ-013 The block SHALL time-share one ALU datapath between two requesters via valid/ready handshakes.
REQ-014 The FSM SHALL have exactly two states: IDLE and RESP.
REQ-015 In IDLE, req_ready SHALL equal the grant vector when any req_valid is set, and 2'b00 otherwise.
REQ-016 req_ready SHALL be 2'b00 in RESP.
REQ-017 On the accept edge (req_valid[i] && req_ready[i]), the block SHALL register a, b, op and owner index i, then move to RESP.
REQ-018 In RESP, resp_valid SHALL be one-hot at the owner index, beginning the cycle after accept (latency 1).
REQ-019 resp_result, resp_status and resp_err SHALL be computed from the registered operands and stay stable until the response handshake.
REQ-020 On resp_valid[i] && resp_ready[i], the FSM SHALL return to IDLE; no new accept in that same cycle (max one op per 2 cycles).
REQ-021 ADD/SUB width rule: {c, result} = a +/- b in N+1 bits; v = signed overflow (operand signs equal after SUB inversion of b, and result sign differs).
REQ-022 AND/OR/SLT SHALL force c = 0 and v = 0; SLT result is unsigned a < b, zero-extended.
REQ-023 For all ops, n = result[N-1] and z = (result == 0).
REQ-024 Illegal opcode (100, 110, 111) SHALL still be accepted and respond with resp_err = 1, result 0, status 4'b0100.
REQ-025 Outside RESP, resp_result, resp_status and resp_err SHALL be driven 0.

Reset
REQ-026 Asserting rst_n low SHALL asynchronously force state IDLE, resp_valid 0, req_ready 0, and all operand/owner registers 0.
REQ-027 Reset SHALL set the last-grant register to 1, so requester 0 wins the first contention.
REQ-028 Reset asserted in RESP SHALL discard the pending response without handshake.

Configuration
REQ-029 With ALU_ARB_RR_EN defined, the grant SHALL be round-robin: on contention, the requester not in last-grant wins; last-grant updates on every accept.
REQ-030 Without ALU_ARB_RR_EN, the grant SHALL be fixed priority, requester 0 over 1, and the last-grant register SHALL not exist.

Structure
REQ-031 The shared package alu_pkg SHALL hold the opcode enum, status bit indices (N=3, Z=2, C=1, V=0) and the state enum.
REQ-032 The arithmetic SHALL live in one sub-module, ALU (combinational, N-parameterized), instantiated once; arbitration and FSM stay in alu_arbiter.

Verification
REQ-033 req0 ADD 5+7 after reset -> req_ready=2'b01 same cycle; next cycle resp_valid=2'b01, result 12, status 4'b0000.
REQ-034 Both valid continuously with RR_EN, resp_ready=2'b11 -> grant order 0,1,0,1; without RR_EN -> 0,0,0,0.
REQ-035 SUB 0x80000000 - 1 -> result 0x7FFFFFFF, status 4'b0001; SUB 3-3 -> result 0, status 4'b0100.
REQ-036 resp_ready held 0 for 3 cycles -> resp_valid, result and status stable, req_ready=2'b00 throughout.
REQ-037 Op 3'b111 -> resp_err=1, result 0, status 4'b0100; next op with a legal opcode -> resp_err=0.
REQ-038 rst_n pulsed low mid-RESP -> resp_valid=0 with no clock edge; first op after release goes to requester 0.
